pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the Enable and flush (Reset) inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three hazard classes: load-use data hazards, taken-branch control hazards and data-memory wait states.
- Updates on posedge clk. Pipeline registers latch on negedge, so each decision is applied half a cycle after it is sampled.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- BRANCH_PENALTY, 2, cycles IF/ID and ID/EX are flushed after a taken branch (1..7).
- MEM_TIMEOUT, 15, maximum consecutive MEM_WAIT cycles before the error flag is raised (1..255).

Ports:
- clk  in  1  pipeline clock.
- Reset  in  1  asynchronous, active-low reset.
- IdRs1  in  5  source register 1 of the instruction in decode.
- IdRs2  in  5  source register 2 of the instruction in decode.
- IdUsesRs1  in  1  decode instruction reads Rs1.
- IdUsesRs2  in  1  decode instruction reads Rs2.
- ExRd  in  5  RD output of ID/EX.
- ExMemRD  in  1  MEMRD output of ID/EX (instruction in EX is a load).
- ExRegWrite  in  1  REGWRITE output of ID/EX.
- BranchTaken  in  1  EX stage resolved a taken branch this cycle.
- MemBusy  in  1  data memory not ready.
- PCEnable  out  1  PC update enable.
- IfIdEnable  out  1  IF/ID Enable.
- IfIdFlush  out  1  IF/ID Reset (bubble).
- IdExEnable  out  1  ID/EX Enable.
- IdExFlush  out  1  ID/EX Reset; loads OPCODE 5'b11111 (NOP).
- ExMemEnable  out  1  EX/MEM Enable.
- State  out  2  RUN=00, LOAD_STALL=01, BRANCH_FLUSH=10, MEM_WAIT=11.
- MemTimeout  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Values while Reset=0:
  - PCEnable=IfIdEnable=IdExEnable=ExMemEnable=0.
  - IfIdFlush=IdExFlush=1, so the pipeline is held full of NOPs.
  - State=RUN, MemTimeout=0, counters=0.
- Output timing: all outputs are registered, decoded from next state at posedge. Inputs are sampled at posedge k; the effect appears at negedge k.
- Load-use hazard (LU) = ExMemRD & ExRegWrite & (ExRd!=0) & ((IdUsesRs1 & IdRs1==ExRd) | (IdUsesRs2 & IdRs2==ExRd)).
- Event priority per cycle: MemBusy > BranchTaken > LU.
- RUN:
  - Outputs: all enables 1, flushes 0.
  - MemBusy -> MEM_WAIT (return state = RUN).
  - else BranchTaken -> BRANCH_FLUSH, cnt=BRANCH_PENALTY.
  - else LU -> LOAD_STALL, cnt=LOAD_STALL_CYCLES.
- LOAD_STALL:
  - Outputs: PCEnable=0, IfIdEnable=0, IdExFlush=1, IdExEnable=1, ExMemEnable=1.
  - cnt decrements each cycle; cnt reaching 0 -> RUN.
  - BranchTaken overrides: -> BRANCH_FLUSH with fresh count.
  - LU re-evaluated on exit; if still true, stall again.
- BRANCH_FLUSH:
  - Outputs: PCEnable=1 (PC loads target), IfIdFlush=1, IdExFlush=1, ExMemEnable=1.
  - cnt decrements each cycle; cnt reaching 0 -> RUN.
  - LU is ignored (decode contents are discarded).
  - A second BranchTaken reloads cnt.
- MEM_WAIT:
  - Outputs: all enables 0, flushes 0 (full freeze).
  - Entered from any state on MemBusy. Return state and cnt are saved, and cnt is frozen.
  - MemBusy=0 -> resume the saved state with the remaining cnt. If saved cnt is 0, go to RUN.
  - The wait counter (8 bits) counts consecutive busy cycles. Reaching MEM_TIMEOUT sets MemTimeout=1 and forces RUN, ignoring MemBusy for that one cycle.
  - MemTimeout clears only on Reset.
- Boundary rules:
  - ExRd=0 never causes a stall.
  - BranchTaken and LU in the same cycle -> BRANCH_FLUSH only.
  - Reset asserted mid-stall forces the reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - Adds outputs StallCount[15:0], FlushCount[15:0] and WaitCount[15:0].
  - Each counts cycles spent in LOAD_STALL, BRANCH_FLUSH and MEM_WAIT respectively.
  - Counters saturate at 16'hFFFF and clear on Reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release:
  - Stimulus: Reset=0 for 3 cycles, then Reset=1 with all inputs 0.
  - Required: flushes=1 and enables=0 while in reset. From the first posedge after release: enables=1, flushes=0, State=00.
- Load-use:
  - Stimulus: ExMemRD=1, ExRegWrite=1, ExRd=5, IdRs1=5, IdUsesRs1=1 for one cycle.
  - Required: exactly 1 cycle with State=01, PCEnable=0, IdExFlush=1, then RUN.
- ExRd=0 and unused source:
  - Stimulus (a): ExRd=0 with IdRs1=0. Stimulus (b): IdRs2=5 matching ExRd with IdUsesRs2=0.
  - Required: no stall in either case.
- Branch during stall:
  - Stimulus: LU at cycle 0, BranchTaken at cycle 1, with LOAD_STALL_CYCLES=3.
  - Required: BRANCH_FLUSH for 2 cycles from cycle 1 (IfIdFlush=IdExFlush=1), then RUN.
- Memory wait during branch flush:
  - Stimulus: MemBusy=1 for 4 cycles, raised after 1 flush cycle.
  - Required: 4 frozen cycles (State=11, all enables 0), then 1 remaining BRANCH_FLUSH cycle, then RUN.
- Memory timeout:
  - Stimulus: MemBusy held high for 20 cycles, MEM_TIMEOUT=15.
  - Required: MemTimeout=1 after the 15th busy cycle, a one-cycle RUN, then re-entry to MEM_WAIT. MemTimeout stays 1 until Reset.
  - With PIPE_HAZARD_PERF_EN defined: WaitCount=19.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard inputs from the pipeline and stall/flush controls back to it.
// Perf counter signals exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_if;
    logic [4:0]  IdRs1;
    logic [4:0]  IdRs2;
    logic        IdUsesRs1;
    logic        IdUsesRs2;
    logic [4:0]  ExRd;
    logic        ExMemRD;
    logic        ExRegWrite;
    logic        BranchTaken;
    logic        MemBusy;
    logic        PCEnable;
    logic        IfIdEnable;
    logic        IfIdFlush;
    logic        IdExEnable;
    logic        IdExFlush;
    logic        ExMemEnable;
    logic [1:0]  State;
    logic        MemTimeout;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] StallCount;
    logic [15:0] FlushCount;
    logic [15:0] WaitCount;
`endif

    modport slave (
        input  IdRs1, IdRs2, IdUsesRs1, IdUsesRs2, ExRd, ExMemRD, ExRegWrite, BranchTaken, MemBusy,
        output PCEnable, IfIdEnable, IfIdFlush, IdExEnable, IdExFlush, ExMemEnable, State, MemTimeout
`ifdef PIPE_HAZARD_PERF_EN
        , output StallCount, FlushCount, WaitCount
`endif
    );

    modport master (
        output IdRs1, IdRs2, IdUsesRs1, IdUsesRs2, ExRd, ExMemRD, ExRegWrite, BranchTaken, MemBusy,
        input  PCEnable, IfIdEnable, IfIdFlush, IdExEnable, IdExFlush, ExMemEnable, State, MemTimeout
`ifdef PIPE_HAZARD_PERF_EN
        , input StallCount, FlushCount, WaitCount
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer resolving load-use, taken-branch and memory-wait hazards.
// Define PIPE_HAZARD_PERF_EN to add saturating per-state cycle counters.
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY    = 2,
    parameter int MEM_TIMEOUT       = 15
) (
    input logic          clk,
    input logic          Reset,
    pipe_hazard_if.slave hz
);
    typedef enum logic [1:0] {
        RUN          = 2'b00,
        LOAD_STALL   = 2'b01,
        BRANCH_FLUSH = 2'b10,
        MEM_WAIT     = 2'b11
    } state_t;

    state_t     state_q, state_d, ret_q, ret_d;
    logic [2:0] cnt_q, cnt_d, dec;
    logic [7:0] wcnt_q, wcnt_d;
    logic       to_q, to_d, lu;
    logic [5:0] ctl_q;

    // {PCEnable, IfIdEnable, IfIdFlush, IdExEnable, IdExFlush, ExMemEnable}
    function automatic logic [5:0] ctl_of(input state_t s);
        return s == RUN ? 6'b110101 : s == LOAD_STALL ? 6'b000111 :
               s == BRANCH_FLUSH ? 6'b101111 : 6'b000000;
    endfunction

    assign lu = hz.ExMemRD & hz.ExRegWrite & (hz.ExRd != 5'd0) &
                ((hz.IdUsesRs1 & (hz.IdRs1 == hz.ExRd)) | (hz.IdUsesRs2 & (hz.IdRs2 == hz.ExRd)));
    assign dec = cnt_q - 3'd1;

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        to_d    = to_q;
        if (state_q == MEM_WAIT) begin
            if (!hz.MemBusy) begin
                state_d = cnt_q == 3'd0 ? RUN : ret_q;
                wcnt_d  = 8'd0;
            end else if (wcnt_q == 8'(MEM_TIMEOUT)) begin
                state_d = RUN;
                cnt_d   = 3'd0;
                wcnt_d  = 8'd0;
                to_d    = 1'b1;
            end else
                wcnt_d = wcnt_q + 8'd1;
        end else if (hz.MemBusy) begin
            // the cycle just completed counts against the remaining penalty
            state_d = MEM_WAIT;
            ret_d   = state_q;
            cnt_d   = state_q == RUN ? 3'd0 : dec;
            wcnt_d  = 8'd1;
        end else if (hz.BranchTaken) begin
            state_d = BRANCH_FLUSH;
            cnt_d   = 3'(BRANCH_PENALTY);
        end else if (state_q == BRANCH_FLUSH) begin
            state_d = dec == 3'd0 ? RUN : BRANCH_FLUSH;
            cnt_d   = dec;
        end else if (state_q == LOAD_STALL && dec != 3'd0)
            cnt_d = dec;
        else if (lu) begin
            state_d = LOAD_STALL;
            cnt_d   = 3'(LOAD_STALL_CYCLES);
        end else begin
            state_d = RUN;
            cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge Reset)
        if (!Reset) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= 3'd0;
            wcnt_q  <= 8'd0;
            to_q    <= 1'b0;
            ctl_q   <= 6'b001010;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            to_q    <= to_d;
            ctl_q   <= ctl_of(state_d);
        end

    assign {hz.PCEnable, hz.IfIdEnable, hz.IfIdFlush, hz.IdExEnable, hz.IdExFlush, hz.ExMemEnable} = ctl_q;
    assign hz.State      = state_q;
    assign hz.MemTimeout = to_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_q, flush_q, wait_q;

    always_ff @(posedge clk or negedge Reset)
        if (!Reset) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
            wait_q  <= 16'd0;
        end else begin
            if (state_q == LOAD_STALL && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (state_q == BRANCH_FLUSH && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
            if (state_q == MEM_WAIT && wait_q != 16'hFFFF) wait_q <= wait_q + 16'd1;
        end

    assign hz.StallCount = stall_q;
    assign hz.FlushCount = flush_q;
    assign hz.WaitCount  = wait_q;
`endif
endmodule
